// File: rtl/llsc_reservation_ctrl.sv
// llsc_reservation_ctrl
// ---------------------
// Sequences LoongArch LL.W / SC.W in the memory stage. Owns the architectural
// LLbit and the reservation address, drives a single-outstanding memory port
// and returns the rd writeback (load data for LL, 0/1 success flag for SC).
//
// atomic_op_type encoding: 2'b01 = ATOMIC_LL, 2'b10 = ATOMIC_SC,
// 2'b00 = INVALID_OP_2B (2'b11 is treated the same way: consumed, dropped).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   op_valid/op_ready          op handshake (ready only in IDLE)
//   atomic_op_type, op_addr,
//   op_wdata, op_rd            op payload, latched at acceptance
//   mem_req_*                  memory request (we=1 store, we=0 load)
//   mem_resp_valid/rdata       memory response, one per accepted request
//   snoop_st_valid/addr        observed stores; granule hit clears LLbit
//   llbit_clr                  ERTN/exception clear of LLbit
//   wb_valid/wb_rd/wb_data     one-cycle writeback pulse
//   llbit, res_addr            architectural reservation state
// All outputs are registered.

module llsc_reservation_ctrl #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned RES_GRAN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        atomic_op_type,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [4:0]        op_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  input  logic              snoop_st_valid,
  input  logic [ADDR_W-1:0] snoop_st_addr,
  input  logic              llbit_clr,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              llbit,
  output logic [ADDR_W-1:0] res_addr
);

  localparam logic [1:0] ATOMIC_LL = 2'b01;
  localparam logic [1:0] ATOMIC_SC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_REQ,
    S_LD_RESP,
    S_ST_REQ,
    S_ST_RESP,
    S_WB
  } state_e;

  function automatic logic gran_eq(input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] b);
    return (a >> RES_GRAN_LOG2) == (b >> RES_GRAN_LOG2);
  endfunction

  function automatic logic [ADDR_W-1:0] gran_align(input logic [ADDR_W-1:0] a);
    return (a >> RES_GRAN_LOG2) << RES_GRAN_LOG2;
  endfunction

  state_e              state_q, state_d;
  logic                op_ready_q, op_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                mem_req_we_q, mem_req_we_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [31:0]         mem_req_wdata_q, mem_req_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                llbit_q, llbit_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;

  logic                accept;
  logic                clr_hit;
  logic [ADDR_W-1:0]   snoop_tgt;
  logic                ll_set;
  logic                ll_kill;
  logic [31:0]         wb_val;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    res_addr_d = res_addr_q;
    ll_set     = 1'b0;
    ll_kill    = 1'b0;
    wb_val     = '0;

    accept = op_valid && op_ready_q;

    // A snoop landing with the LL response is checked against the
    // reservation being formed, so that it still wins over the new set.
    snoop_tgt = (state_q == S_LD_RESP && mem_resp_valid) ? gran_align(addr_q)
                                                         : res_addr_q;
    clr_hit = llbit_clr || (snoop_st_valid && gran_eq(snoop_st_addr, snoop_tgt));

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = op_addr;
          wdata_d = op_wdata;
          rd_d    = op_rd;
          if (atomic_op_type == ATOMIC_LL) begin
            state_d = S_LD_REQ;
          end else if (atomic_op_type == ATOMIC_SC) begin
            // Decision uses the pre-clear LLbit; a same-cycle clear is
            // handled by the abort path in ST_REQ.
            if (llbit_q && gran_eq(op_addr, res_addr_q)) begin
              state_d = S_ST_REQ;
            end else begin
              state_d = S_WB;
              ll_kill = 1'b1;
            end
          end
        end
      end
      S_LD_REQ: begin
        if (mem_req_ready) state_d = S_LD_RESP;
      end
      S_LD_RESP: begin
        if (mem_resp_valid) begin
          state_d    = S_WB;
          wb_val     = mem_resp_rdata;
          ll_set     = 1'b1;
          res_addr_d = gran_align(addr_q);
        end
      end
      S_ST_REQ: begin
        if (mem_req_valid_q && mem_req_ready) begin
          state_d = S_ST_RESP;
        end else if (!llbit_q || clr_hit) begin
          state_d = S_WB;
        end
      end
      S_ST_RESP: begin
        if (mem_resp_valid) begin
          state_d = S_WB;
          wb_val  = 32'd1;
          ll_kill = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    llbit_d = (llbit_q || ll_set) && !clr_hit && !ll_kill;

    // A store request is only raised while the reservation still holds.
    mem_req_valid_d = (state_d == S_LD_REQ) || (state_d == S_ST_REQ && llbit_d);
    mem_req_we_d    = mem_req_valid_d && (state_d == S_ST_REQ);
    mem_req_addr_d  = mem_req_valid_d ? addr_d : '0;
    mem_req_wdata_d = mem_req_we_d ? wdata_d : '0;

    wb_valid_d = (state_d == S_WB);
    wb_rd_d    = wb_valid_d ? rd_d : '0;
    wb_data_d  = wb_valid_d ? wb_val : '0;

    op_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      op_ready_q      <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rd_q            <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      llbit_q         <= 1'b0;
      res_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      op_ready_q      <= op_ready_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rd_q            <= rd_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      llbit_q         <= llbit_d;
      res_addr_q      <= res_addr_d;
    end
  end

  assign op_ready      = op_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign llbit         = llbit_q;
  assign res_addr      = res_addr_q;

endmodule

// File: tb/tb_llsc_reservation_ctrl.sv
// Testbench for llsc_reservation_ctrl: directed LL/SC scenarios followed by
// randomized op sequences, checked against a transaction-level model of the
// LLbit/reservation rules.
module tb_llsc_reservation_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned G  = 2;

  localparam logic [1:0] T_INV = 2'b00;
  localparam logic [1:0] T_LL  = 2'b01;
  localparam logic [1:0] T_SC  = 2'b10;

  logic          clk, rst_n;
  logic          op_valid, op_ready;
  logic [1:0]    atomic_op_type;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic [4:0]    op_rd;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_wdata;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_rdata;
  logic          snoop_st_valid;
  logic [AW-1:0] snoop_st_addr;
  logic          llbit_clr;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          llbit;
  logic [AW-1:0] res_addr;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural LLbit and granule-aligned reservation.
  logic          m_llbit;
  logic [AW-1:0] m_res;

  llsc_reservation_ctrl #(.ADDR_W(AW), .RES_GRAN_LOG2(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .atomic_op_type(atomic_op_type), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .snoop_st_valid(snoop_st_valid), .snoop_st_addr(snoop_st_addr),
    .llbit_clr(llbit_clr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .llbit(llbit), .res_addr(res_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gmatch(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a / (1 << G)) == (b / (1 << G));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    op_valid       = 1'b0;
    atomic_op_type = T_INV;
    op_addr        = '0;
    op_wdata       = '0;
    op_rd          = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    snoop_st_valid = 1'b0;
    snoop_st_addr  = '0;
    llbit_clr      = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, "_llbit"}, 32'(llbit), 32'(m_llbit));
    chk({tag, "_res_addr"}, res_addr, m_res);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_req_we"}, 32'(mem_req_we), 32'd0);
    chk({tag, "_req_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_llbit"}, 32'(llbit), 32'd0);
    chk({tag, "_res_addr"}, res_addr, 32'd0);
  endtask

  task automatic do_ll(input logic [AW-1:0] a, input logic [31:0] rdata,
                       input logic [4:0] rd, input int req_dly, input int resp_dly,
                       input bit clr_at_resp, input bit snp_at_resp,
                       input logic [AW-1:0] sa);
    op_valid = 1'b1; atomic_op_type = T_LL; op_addr = a;
    op_wdata = $urandom; op_rd = rd;
    step();
    op_valid = 1'b0; op_addr = $urandom; op_rd = 5'($urandom);
    chk("ll_req_valid", 32'(mem_req_valid), 32'd1);
    chk("ll_req_we", 32'(mem_req_we), 32'd0);
    chk("ll_req_addr", mem_req_addr, a);
    chk("ll_op_ready", 32'(op_ready), 32'd0);
    for (int i = 0; i < req_dly; i++) begin
      step();
      chk("ll_req_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("ll_req_hold_addr", mem_req_addr, a);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("ll_req_drop", 32'(mem_req_valid), 32'd0);
    for (int i = 0; i < resp_dly; i++) begin
      step();
      chk("ll_wait_wb", 32'(wb_valid), 32'd0);
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    llbit_clr = clr_at_resp; snoop_st_valid = snp_at_resp; snoop_st_addr = sa;
    m_res   = (a >> G) << G;
    m_llbit = !(clr_at_resp || (snp_at_resp && gmatch(sa, a)));
    step();
    mem_resp_valid = 1'b0; llbit_clr = 1'b0; snoop_st_valid = 1'b0;
    chk("ll_wb_valid", 32'(wb_valid), 32'd1);
    chk("ll_wb_rd", 32'(wb_rd), 32'(rd));
    chk("ll_wb_data", wb_data, rdata);
    chk("ll_llbit", 32'(llbit), 32'(m_llbit));
    chk("ll_res_addr", res_addr, m_res);
    step();
    chk("ll_wb_end", 32'(wb_valid), 32'd0);
    chk_state("ll_done");
  endtask

  task automatic do_sc(input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input int req_dly, input int abort_at,
                       input bit abort_by_clr, input logic [AW-1:0] abort_sa,
                       input bit clr_at_accept, input bit snp_in_resp);
    bit pre, hit, done;
    pre  = m_llbit && gmatch(a, m_res);
    done = 1'b0;
    op_valid = 1'b1; atomic_op_type = T_SC; op_addr = a; op_wdata = wd; op_rd = rd;
    llbit_clr = clr_at_accept;
    step();
    op_valid = 1'b0; op_addr = $urandom; op_wdata = $urandom; llbit_clr = 1'b0;
    if (clr_at_accept) m_llbit = 1'b0;
    if (!pre) begin
      m_llbit = 1'b0;
      chk("scf_wb_valid", 32'(wb_valid), 32'd1);
      chk("scf_wb_data", wb_data, 32'd0);
      chk("scf_wb_rd", 32'(wb_rd), 32'(rd));
      chk("scf_no_req", 32'(mem_req_valid), 32'd0);
      chk("scf_llbit", 32'(llbit), 32'd0);
    end else if (clr_at_accept) begin
      chk("scc_no_req", 32'(mem_req_valid), 32'd0);
      chk("scc_no_wb", 32'(wb_valid), 32'd0);
      step();
      chk("scc_wb_valid", 32'(wb_valid), 32'd1);
      chk("scc_wb_data", wb_data, 32'd0);
      chk("scc_no_req2", 32'(mem_req_valid), 32'd0);
    end else begin
      chk("sc_req_valid", 32'(mem_req_valid), 32'd1);
      chk("sc_req_we", 32'(mem_req_we), 32'd1);
      chk("sc_req_addr", mem_req_addr, a);
      chk("sc_req_wdata", mem_req_wdata, wd);
      for (int i = 0; i < req_dly && !done; i++) begin
        hit = 1'b0;
        if (i == abort_at) begin
          llbit_clr = abort_by_clr; snoop_st_valid = !abort_by_clr;
          snoop_st_addr = abort_sa;
          hit = abort_by_clr || gmatch(abort_sa, m_res);
        end
        step();
        llbit_clr = 1'b0; snoop_st_valid = 1'b0;
        if (hit) begin
          m_llbit = 1'b0;
          done = 1'b1;
          chk("sca_req_drop", 32'(mem_req_valid), 32'd0);
          chk("sca_wb_valid", 32'(wb_valid), 32'd1);
          chk("sca_wb_data", wb_data, 32'd0);
          chk("sca_llbit", 32'(llbit), 32'd0);
        end else begin
          chk("sc_hold_valid", 32'(mem_req_valid), 32'd1);
          chk("sc_hold_addr", mem_req_addr, a);
          chk("sc_hold_wdata", mem_req_wdata, wd);
        end
      end
      if (!done) begin
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("sc_req_drop", 32'(mem_req_valid), 32'd0);
        chk("sc_no_wb_yet", 32'(wb_valid), 32'd0);
        mem_resp_valid = 1'b1;
        snoop_st_valid = snp_in_resp; snoop_st_addr = a;
        step();
        mem_resp_valid = 1'b0; snoop_st_valid = 1'b0;
        m_llbit = 1'b0;
        chk("scs_wb_valid", 32'(wb_valid), 32'd1);
        chk("scs_wb_data", wb_data, 32'd1);
        chk("scs_wb_rd", 32'(wb_rd), 32'(rd));
        chk("scs_llbit", 32'(llbit), 32'd0);
      end
    end
    step();
    chk("sc_wb_end", 32'(wb_valid), 32'd0);
    chk_state("sc_done");
  endtask

  task automatic do_invalid(input logic [1:0] t);
    op_valid = 1'b1; atomic_op_type = t; op_addr = $urandom; op_rd = 5'($urandom);
    step();
    op_valid = 1'b0;
    chk("inv_no_wb", 32'(wb_valid), 32'd0);
    chk("inv_no_req", 32'(mem_req_valid), 32'd0);
    chk_state("inv");
  endtask

  task automatic do_snoop(input logic [AW-1:0] sa, input bit clr);
    snoop_st_valid = 1'b1; snoop_st_addr = sa; llbit_clr = clr;
    if (clr || gmatch(sa, m_res)) m_llbit = 1'b0;
    step();
    snoop_st_valid = 1'b0; llbit_clr = 1'b0;
    chk_state("snoop");
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] base [3];
    base[0] = 32'h1000; base[1] = 32'h1004; base[2] = 32'h2000;
    return base[$urandom_range(0, 2)] + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    clear_inputs();
    m_llbit = 1'b0;
    m_res   = '0;
    rst_n   = 1'b0;
    repeat (3) step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    step();
    chk_state("post_rst");

    // LL then matching SC succeeds.
    do_ll(32'h1000, 32'hDEADBEEF, 5'd5, 1, 1, 0, 0, '0);
    do_sc(32'h1000, 32'h55, 5'd6, 0, -1, 0, '0, 0, 0);
    // SC without reservation fails with no memory access.
    do_sc(32'h2000, 32'h77, 5'd7, 0, -1, 0, '0, 0, 0);
    // Same-granule snoop kills the reservation; a neighbouring granule does not.
    do_ll(32'h1000, 32'h11, 5'd1, 0, 0, 0, 0, '0);
    do_snoop(32'h1002, 0);
    do_sc(32'h1000, 32'h1, 5'd2, 0, -1, 0, '0, 0, 0);
    do_ll(32'h1000, 32'h22, 5'd1, 0, 0, 0, 0, '0);
    do_snoop(32'h1004, 0);
    do_sc(32'h1000, 32'h2, 5'd2, 0, -1, 0, '0, 0, 0);
    // Clear while the store waits for ready aborts it.
    do_ll(32'h1000, 32'h33, 5'd3, 0, 0, 0, 0, '0);
    do_sc(32'h1000, 32'h3, 5'd4, 3, 1, 1, '0, 0, 0);
    // Clear coincident with the LL response: data returned, llbit stays 0.
    do_ll(32'h1000, 32'hCAFEF00D, 5'd8, 0, 2, 1, 0, '0);
    do_sc(32'h1000, 32'h4, 5'd9, 0, -1, 0, '0, 0, 0);
    // Clear coincident with SC acceptance.
    do_ll(32'h3000, 32'h44, 5'd10, 0, 0, 0, 0, '0);
    do_sc(32'h3000, 32'h5, 5'd11, 2, -1, 0, '0, 1, 0);
    // New LL replaces the reservation.
    do_ll(32'h1000, 32'h55, 5'd12, 0, 0, 0, 0, '0);
    do_ll(32'h2009, 32'h66, 5'd13, 2, 0, 0, 0, '0);
    do_sc(32'h1000, 32'h6, 5'd14, 0, -1, 0, '0, 0, 0);
    // Snoop after the store is accepted does not change the result.
    do_ll(32'h2008, 32'h77, 5'd15, 0, 0, 0, 0, '0);
    do_sc(32'h2008, 32'h7, 5'd16, 1, -1, 0, '0, 0, 1);

    // Reset asserted while waiting for the LL response.
    do_ll(32'h1000, 32'h88, 5'd17, 0, 0, 0, 0, '0);
    op_valid = 1'b1; atomic_op_type = T_LL; op_addr = 32'h1000; op_rd = 5'd18;
    step();
    op_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_llbit = 1'b0; m_res = '0;
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD;
    step();
    mem_resp_valid = 1'b0;
    chk("rst_stale_wb", 32'(wb_valid), 32'd0);
    chk_state("rst_rel");
    step();
    chk("rst_stale_wb2", 32'(wb_valid), 32'd0);
    do_invalid(T_INV);
    do_invalid(2'b11);

    // Randomized op sequences.
    for (int n = 0; n < 60; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        do_ll(rand_addr(), $urandom, 5'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0), rand_addr());
      end else if (sel < 8) begin
        do_sc(rand_addr(), $urandom, 5'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : -1,
              ($urandom_range(0, 1) == 0), rand_addr(),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0));
      end else if (sel == 8) begin
        do_snoop(rand_addr(), ($urandom_range(0, 3) == 0));
      end else begin
        do_invalid(($urandom_range(0, 1) == 0) ? T_INV : 2'b11);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
